// File: rtl/parking_occupancy_ctrl.sv
// ---------------------------------------------------------------------------
// parking_occupancy_ctrl
//   Gate/occupancy controller for the parking lot. It keeps the registered
//   occupancy count. It adds or subtracts one from that count through an
//   external combinational 8-bit adder_subtractor. It then sequences the
//   entry and exit barriers.
//
// Parameters
//   CAPACITY     number of slots (1..255)
//   GATE_CYCLES  cycles a barrier stays open per car (1..255)
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   entry_req, exit_req   1-cycle sensor pulses
//   as_s/as_a/as_b        operands driven to the adder (S: 0=add, 1=sub)
//   as_sum/as_cout        adder result (Cout=1 on subtract means no borrow)
//   count, free_slots     occupancy and remaining slots
//   full, empty           occupancy flags
//   entry_open/exit_open  barrier controls
//   busy                  FSM not idle; requests are dropped while high
//   reject, err           1-cycle pulses: request refused / arithmetic fault
// ---------------------------------------------------------------------------
module parking_occupancy_ctrl #(
  parameter int CAPACITY    = 200,
  parameter int GATE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  output logic       as_s,
  output logic [7:0] as_a,
  output logic [7:0] as_b,
  input  logic [7:0] as_sum,
  input  logic       as_cout,
  output logic [7:0] count,
  output logic [7:0] free_slots,
  output logic       full,
  output logic       empty,
  output logic       entry_open,
  output logic       exit_open,
  output logic       busy,
  output logic       reject,
  output logic       err
);

  localparam logic [7:0] CAP       = 8'(CAPACITY);
  localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ENT_CALC,
    ENT_GATE,
    EXT_CALC,
    EXT_GATE
  } state_e;

  state_e     state_q,    state_d;
  logic [7:0] count_q,    count_d;
  logic [7:0] gate_cnt_q, gate_cnt_d;
  logic       reject_q,   reject_d;
  logic       err_q,      err_d;

  // Status flags come only from the registered count.
  assign count      = count_q;
  assign full       = (count_q == CAP);
  assign empty      = (count_q == 8'd0);
  assign free_slots = CAP - count_q;
  assign reject     = reject_q;
  assign err        = err_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 8'd0;
      gate_cnt_q <= 8'd0;
      reject_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      gate_cnt_q <= gate_cnt_d;
      reject_q   <= reject_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    gate_cnt_d = gate_cnt_q;
    reject_d   = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Exit wins. If both pulses arrive together, the entry is not looked
        // at, even when the exit itself is refused.
        if (exit_req) begin
          if (!empty) state_d  = EXT_CALC;
          else        reject_d = 1'b1;
        end else if (entry_req) begin
          if (!full) state_d  = ENT_CALC;
          else       reject_d = 1'b1;
        end
      end

      ENT_CALC: begin
        // A carry on count+1 means the adder result is not trustworthy.
        if (!as_cout) begin
          count_d    = as_sum;
          gate_cnt_d = GATE_LOAD;
          state_d    = ENT_GATE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      EXT_CALC: begin
        // On subtract, Cout=1 means no borrow.
        if (as_cout) begin
          count_d    = as_sum;
          gate_cnt_d = GATE_LOAD;
          state_d    = EXT_GATE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      ENT_GATE, EXT_GATE: begin
        if (gate_cnt_q == 8'd0) state_d = IDLE;
        else                    gate_cnt_d = gate_cnt_q - 8'd1;
      end

      default: state_d = IDLE;
    endcase
  end

  // Output decode. These outputs depend on state only.
  always_comb begin
    as_a       = count_q;
    as_s       = (state_q == EXT_CALC);
    as_b       = (state_q == ENT_CALC || state_q == EXT_CALC) ? 8'd1 : 8'd0;
    entry_open = (state_q == ENT_GATE);
    exit_open  = (state_q == EXT_GATE);
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
module tb_parking_occupancy_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- DUT A: default parameters (CAPACITY 200, gate 16) -----
  logic       a_rst, a_entry, a_exit, a_s, a_cout, force_cout;
  logic [7:0] a_a, a_b, a_sum, a_count, a_free;
  logic       a_full, a_empty, a_eopen, a_xopen, a_busy, a_reject, a_err;

  parking_occupancy_ctrl dut_a (
    .clk(clk), .rst(a_rst), .entry_req(a_entry), .exit_req(a_exit),
    .as_s(a_s), .as_a(a_a), .as_b(a_b), .as_sum(a_sum), .as_cout(a_cout),
    .count(a_count), .free_slots(a_free), .full(a_full), .empty(a_empty),
    .entry_open(a_eopen), .exit_open(a_xopen), .busy(a_busy),
    .reject(a_reject), .err(a_err)
  );

  // Reference adder_subtractor. On subtract, Cout=1 means no borrow.
  always_comb begin
    if (a_s) {a_cout, a_sum} = {1'b0, a_a} + {1'b0, ~a_b} + 9'd1;
    else     {a_cout, a_sum} = {1'b0, a_a} + {1'b0, a_b};
    if (force_cout) a_cout = 1'b1;
  end

  // ---------------- DUT B: CAPACITY 3, gate 2 -----------------------------
  logic       b_rst, b_entry, b_exit, b_s, b_cout;
  logic [7:0] b_a, b_b, b_sum, b_count, b_free;
  logic       b_full, b_empty, b_eopen, b_xopen, b_busy, b_reject, b_err;

  parking_occupancy_ctrl #(.CAPACITY(3), .GATE_CYCLES(2)) dut_b (
    .clk(clk), .rst(b_rst), .entry_req(b_entry), .exit_req(b_exit),
    .as_s(b_s), .as_a(b_a), .as_b(b_b), .as_sum(b_sum), .as_cout(b_cout),
    .count(b_count), .free_slots(b_free), .full(b_full), .empty(b_empty),
    .entry_open(b_eopen), .exit_open(b_xopen), .busy(b_busy),
    .reject(b_reject), .err(b_err)
  );

  always_comb begin
    if (b_s) {b_cout, b_sum} = {1'b0, b_a} + {1'b0, ~b_b} + 9'd1;
    else     {b_cout, b_sum} = {1'b0, b_a} + {1'b0, b_b};
  end

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic en, input logic ex);
    a_entry = en;
    a_exit  = ex;
    tick();
    a_entry = 1'b0;
    a_exit  = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    for (int i = 0; i < 64 && a_busy; i++) tick();
    check(tag, a_busy, 0);
  endtask

  task automatic entry_a();
    pulse_a(1'b1, 1'b0);
    tick();
    wait_idle_a("entry_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; a_entry = 1'b0; a_exit = 1'b0; force_cout = 1'b0;
    b_rst = 1'b1; b_entry = 1'b0; b_exit = 1'b0;

    // T1: reset state.
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    check("rst_count", a_count, 0);
    check("rst_empty", a_empty, 1);
    check("rst_free",  a_free, 200);
    check("rst_full",  a_full, 0);
    check("rst_eopen", a_eopen, 0);
    check("rst_xopen", a_xopen, 0);
    check("rst_busy",  a_busy, 0);
    check("rst_as_b",  a_b, 0);

    // T5a: exit when the lot is empty gives a single reject pulse.
    pulse_a(1'b0, 1'b1);
    check("exit_empty_reject", a_reject, 1);
    check("exit_empty_busy",   a_busy, 0);
    tick();
    check("exit_empty_reject_end", a_reject, 0);
    check("exit_empty_count",      a_count, 0);

    // T4: simultaneous requests at count 2. The exit path is taken.
    entry_a(); entry_a();
    check("pre_t4_count", a_count, 2);
    pulse_a(1'b1, 1'b1);
    check("simul_calc_s", a_s, 1);
    check("simul_calc_b", a_b, 1);
    tick();
    check("simul_count", a_count, 1);
    check("simul_xopen", a_xopen, 1);
    check("simul_eopen", a_eopen, 0);
    wait_idle_a("simul_done");
    check("simul_count_after", a_count, 1);

    // T2: entry at count 5. Check the latency and the 16-cycle gate.
    for (int i = 0; i < 4; i++) entry_a();
    check("pre_t2_count", a_count, 5);
    pulse_a(1'b1, 1'b0);
    check("t2_calc_s",    a_s, 0);
    check("t2_calc_b",    a_b, 1);
    check("t2_calc_busy", a_busy, 1);
    check("t2_calc_count", a_count, 5);
    tick();
    check("t2_count", a_count, 6);
    check("t2_free",  a_free, 194);
    check("t2_open",  a_eopen, 1);
    check("t2_as_b_gate", a_b, 0);
    for (int i = 0; i < 15; i++) tick();
    check("t2_open_last", a_eopen, 1);
    tick();
    check("t2_closed", a_eopen, 0);
    check("t2_idle",   a_busy, 0);

    // T5b: an entry pulse during ENT_GATE is dropped without a reject.
    pulse_a(1'b1, 1'b0);
    tick();
    check("t5_count", a_count, 7);
    tick(); tick();
    pulse_a(1'b1, 1'b0);
    check("busy_drop_reject", a_reject, 0);
    wait_idle_a("busy_drop_done");
    tick(); tick();
    check("busy_drop_count", a_count, 7);
    check("busy_drop_idle",  a_busy, 0);

    // T6: reset during cycle 5 of EXT_GATE.
    pulse_a(1'b0, 1'b1);
    tick();
    check("t6_gate_count", a_count, 6);
    check("t6_gate_open",  a_xopen, 1);
    for (int i = 0; i < 4; i++) tick();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    check("midrst_xopen", a_xopen, 0);
    check("midrst_busy",  a_busy, 0);
    check("midrst_count", a_count, 0);
    check("midrst_free",  a_free, 200);

    // A forced carry in ENT_CALC gives an err pulse and holds the count.
    force_cout = 1'b1;
    pulse_a(1'b1, 1'b0);
    check("err_calc_b", a_b, 1);
    tick();
    force_cout = 1'b0;
    check("err_pulse", a_err, 1);
    check("err_count", a_count, 0);
    check("err_busy",  a_busy, 0);
    check("err_eopen", a_eopen, 0);
    tick();
    check("err_pulse_end", a_err, 0);

    // T3: DUT B with CAPACITY 3 fills up, then refuses the next entry.
    for (int n = 0; n < 3; n++) begin
      b_entry = 1'b1; tick(); b_entry = 1'b0;
      for (int i = 0; i < 16 && (b_busy || b_eopen); i++) tick();
    end
    check("full_count", b_count, 3);
    check("full_flag",  b_full, 1);
    check("full_free",  b_free, 0);
    b_entry = 1'b1; tick(); b_entry = 1'b0;
    check("full_reject", b_reject, 1);
    check("full_busy",   b_busy, 0);
    tick();
    check("full_reject_end", b_reject, 0);
    check("full_count_held", b_count, 3);
    check("full_eopen",      b_eopen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
